mrv2_issue: RTL

Multi-threaded in-order issue stage for the MRV2 barrel core; parametrised successor to the MRV1 issue stage. It holds decoded instructions in a per-thread FIFO and tracks per-thread register hazards in a scoreboard. Each cycle it picks one thread round-robin from those whose head instruction has clear operands and a ready functional unit. It sits between decode and the register-file read / execute fan-out; per-thread flush discards a thread's buffered work.

---
 rtl/mrv2_issue.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/mrv2_issue.sv
// Multi-threaded in-order issue stage: per-thread instruction FIFOs, a per-thread
// register scoreboard and a round-robin picker that issues at most one thread per cycle.
module mrv2_issue #(
  parameter int NUM_THREADS_P   = 8,
  parameter int BUF_DEPTH_P     = 4,
  parameter int NUM_FU_P        = 6,
  parameter int RF_ADDR_WIDTH_P = 5,
  parameter int PAYLOAD_WIDTH_P = 64,
  localparam int tid_width_lp   = (NUM_THREADS_P > 1) ? $clog2(NUM_THREADS_P) : 1,
  localparam int fu_width_lp    = (NUM_FU_P > 1) ? $clog2(NUM_FU_P) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       dec_vld_i,
  input  logic [tid_width_lp-1:0]    dec_tid_i,
  input  logic [fu_width_lp-1:0]     dec_fu_i,
  input  logic                       dec_rs0_vld_i,
  input  logic [RF_ADDR_WIDTH_P-1:0] dec_rs0_addr_i,
  input  logic                       dec_rs1_vld_i,
  input  logic [RF_ADDR_WIDTH_P-1:0] dec_rs1_addr_i,
  input  logic                       dec_rd_vld_i,
  input  logic [RF_ADDR_WIDTH_P-1:0] dec_rd_addr_i,
  input  logic [PAYLOAD_WIDTH_P-1:0] dec_payload_i,
  output logic [NUM_THREADS_P-1:0]   dec_rdy_o,
  input  logic [NUM_FU_P-1:0]        exec_fu_rdy_i,
  output logic                       issue_vld_o,
  output logic [tid_width_lp-1:0]    issue_tid_o,
  output logic [NUM_FU_P-1:0]        issue_fu_req_o,
  output logic [RF_ADDR_WIDTH_P-1:0] issue_rs0_addr_o,
  output logic [RF_ADDR_WIDTH_P-1:0] issue_rs1_addr_o,
  output logic                       issue_rd_vld_o,
  output logic [RF_ADDR_WIDTH_P-1:0] issue_rd_addr_o,
  output logic [PAYLOAD_WIDTH_P-1:0] issue_payload_o,
  input  logic                       wb_vld_i,
  input  logic [tid_width_lp-1:0]    wb_tid_i,
  input  logic [RF_ADDR_WIDTH_P-1:0] wb_rd_addr_i,
  input  logic                       flush_i,
  input  logic [tid_width_lp-1:0]    flush_tid_i
);

  localparam int cnt_width_lp = $clog2(BUF_DEPTH_P + 1);
  localparam int ptr_width_lp = (BUF_DEPTH_P > 1) ? $clog2(BUF_DEPTH_P) : 1;
  localparam int num_regs_lp  = 1 << RF_ADDR_WIDTH_P;
  localparam int fu_pad_lp    = 1 << fu_width_lp;
  localparam logic [cnt_width_lp-1:0] depth_lp    = cnt_width_lp'(BUF_DEPTH_P);
  localparam logic [ptr_width_lp-1:0] ptr_last_lp = ptr_width_lp'(BUF_DEPTH_P - 1);

  typedef struct packed {
    logic [fu_width_lp-1:0]     fu;
    logic                       rs0_vld;
    logic [RF_ADDR_WIDTH_P-1:0] rs0;
    logic                       rs1_vld;
    logic [RF_ADDR_WIDTH_P-1:0] rs1;
    logic                       rd_vld;
    logic [RF_ADDR_WIDTH_P-1:0] rd;
    logic [PAYLOAD_WIDTH_P-1:0] payload;
  } entry_t;

  entry_t                  buf_q  [NUM_THREADS_P][BUF_DEPTH_P];
  logic [ptr_width_lp-1:0] head_q [NUM_THREADS_P];
  logic [ptr_width_lp-1:0] head_d [NUM_THREADS_P];
  logic [ptr_width_lp-1:0] tail_q [NUM_THREADS_P];
  logic [ptr_width_lp-1:0] tail_d [NUM_THREADS_P];
  logic [cnt_width_lp-1:0] cnt_q  [NUM_THREADS_P];
  logic [cnt_width_lp-1:0] cnt_d  [NUM_THREADS_P];
  logic [num_regs_lp-1:0]  sb_q   [NUM_THREADS_P];
  logic [num_regs_lp-1:0]  sb_d   [NUM_THREADS_P];
  logic [tid_width_lp-1:0] last_q, last_d;

  logic [NUM_THREADS_P-1:0] elig, flush_hit, enq_hit, deq_hit;
  logic [fu_pad_lp-1:0]     fu_rdy_pad;
  logic                     enq;
  logic                     grant_vld;
  logic [tid_width_lp-1:0]  grant_tid;
  logic [fu_width_lp-1:0]   grant_fu;
  entry_t                   dec_entry;

  assign fu_rdy_pad = fu_pad_lp'(exec_fu_rdy_i);
  assign enq        = dec_vld_i & dec_rdy_o[dec_tid_i];
  assign dec_entry  = '{fu: dec_fu_i, rs0_vld: dec_rs0_vld_i, rs0: dec_rs0_addr_i,
                        rs1_vld: dec_rs1_vld_i, rs1: dec_rs1_addr_i,
                        rd_vld: dec_rd_vld_i, rd: dec_rd_addr_i, payload: dec_payload_i};

  for (genvar gi = 0; gi < NUM_THREADS_P; gi++) begin : g_thr
    logic [fu_width_lp-1:0]     h_fu;
    logic                       h_rs0_vld, h_rs1_vld, h_rd_vld;
    logic [RF_ADDR_WIDTH_P-1:0] h_rs0, h_rs1, h_rd;
    logic [num_regs_lp-1:0]     wb_mask, busy;
    logic                       rs0_blk, rs1_blk, rd_blk;

    assign h_fu      = buf_q[gi][head_q[gi]].fu;
    assign h_rs0_vld = buf_q[gi][head_q[gi]].rs0_vld;
    assign h_rs0     = buf_q[gi][head_q[gi]].rs0;
    assign h_rs1_vld = buf_q[gi][head_q[gi]].rs1_vld;
    assign h_rs1     = buf_q[gi][head_q[gi]].rs1;
    assign h_rd_vld  = buf_q[gi][head_q[gi]].rd_vld;
    assign h_rd      = buf_q[gi][head_q[gi]].rd;

    // A writeback in this cycle already releases its register for the dependent.
    assign wb_mask = (wb_vld_i && wb_tid_i == tid_width_lp'(gi))
                     ? (num_regs_lp'(1) << wb_rd_addr_i) : '0;
    assign busy    = sb_q[gi] & ~wb_mask;
    assign rs0_blk = h_rs0_vld && (h_rs0 != '0) && busy[h_rs0];
    assign rs1_blk = h_rs1_vld && (h_rs1 != '0) && busy[h_rs1];
    assign rd_blk  = h_rd_vld && (h_rd != '0) && busy[h_rd];

    assign flush_hit[gi] = flush_i && (flush_tid_i == tid_width_lp'(gi));
    assign enq_hit[gi]   = enq && (dec_tid_i == tid_width_lp'(gi));
    assign deq_hit[gi]   = grant_vld && (grant_tid == tid_width_lp'(gi));
    assign dec_rdy_o[gi] = (cnt_q[gi] < depth_lp) && !flush_hit[gi];
    assign elig[gi]      = (cnt_q[gi] != '0) && !flush_hit[gi] && !rs0_blk && !rs1_blk
                           && !rd_blk && fu_rdy_pad[h_fu];
  end

  // Scan downwards so the thread closest after last_q is the final (winning) match.
  always_comb begin
    logic [tid_width_lp-1:0] idx;
    grant_vld = 1'b0;
    grant_tid = '0;
    idx       = '0;
    for (int k = NUM_THREADS_P; k >= 1; k--) begin
      idx = tid_width_lp'((int'(last_q) + k) % NUM_THREADS_P);
      if (elig[idx]) begin
        grant_vld = 1'b1;
        grant_tid = idx;
      end
    end
  end

  assign last_d           = grant_vld ? grant_tid : last_q;
  assign grant_fu         = buf_q[grant_tid][head_q[grant_tid]].fu;
  assign issue_vld_o      = grant_vld;
  assign issue_tid_o      = grant_tid;
  assign issue_fu_req_o   = grant_vld ? (NUM_FU_P'(1) << grant_fu) : '0;
  assign issue_rs0_addr_o = buf_q[grant_tid][head_q[grant_tid]].rs0;
  assign issue_rs1_addr_o = buf_q[grant_tid][head_q[grant_tid]].rs1;
  assign issue_rd_vld_o   = buf_q[grant_tid][head_q[grant_tid]].rd_vld;
  assign issue_rd_addr_o  = buf_q[grant_tid][head_q[grant_tid]].rd;
  assign issue_payload_o  = buf_q[grant_tid][head_q[grant_tid]].payload;

  always_comb begin
    for (int t = 0; t < NUM_THREADS_P; t++) begin
      head_d[t] = head_q[t];
      tail_d[t] = tail_q[t];
      cnt_d[t]  = cnt_q[t];
      sb_d[t]   = sb_q[t];
      if (flush_hit[t]) begin
        head_d[t] = '0;
        tail_d[t] = '0;
        cnt_d[t]  = '0;
        sb_d[t]   = '0;
      end else begin
        if (enq_hit[t])
          tail_d[t] = (tail_q[t] == ptr_last_lp) ? '0 : tail_q[t] + ptr_width_lp'(1);
        if (deq_hit[t])
          head_d[t] = (head_q[t] == ptr_last_lp) ? '0 : head_q[t] + ptr_width_lp'(1);
        cnt_d[t] = cnt_q[t] + cnt_width_lp'(enq_hit[t]) - cnt_width_lp'(deq_hit[t]);
        // Clear first so a same-bit set from this cycle's issue takes priority.
        if (wb_vld_i && wb_tid_i == tid_width_lp'(t))
          sb_d[t][wb_rd_addr_i] = 1'b0;
        if (deq_hit[t] && issue_rd_vld_o && issue_rd_addr_o != '0)
          sb_d[t][issue_rd_addr_o] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int t = 0; t < NUM_THREADS_P; t++) begin
        head_q[t] <= '0;
        tail_q[t] <= '0;
        cnt_q[t]  <= '0;
        sb_q[t]   <= '0;
      end
      last_q <= tid_width_lp'(NUM_THREADS_P - 1);
    end else begin
      for (int t = 0; t < NUM_THREADS_P; t++) begin
        head_q[t] <= head_d[t];
        tail_q[t] <= tail_d[t];
        cnt_q[t]  <= cnt_d[t];
        sb_q[t]   <= sb_d[t];
      end
      last_q <= last_d;
    end
  end

  // Entry storage carries no reset; validity is tracked by the counters alone.
  always_ff @(posedge clk_i) begin
    if (enq)
      buf_q[dec_tid_i][tail_q[dec_tid_i]] <= dec_entry;
  end

endmodule
